// File: rtl/core_ldst_multiple_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_ldst_multiple_seq_pkg
// Description : Shared ISA/uarch types used by the LDM/STM sequencer: word and
//               register-number types, the decoded LDM/STM record, the
//               sequencer state encoding and a popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package core_ldst_multiple_seq_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned REGNUM_W = 4;
    localparam int unsigned NUM_REGS = 16;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [REGNUM_W-1:0] reg_num_t;

    // Decoded LDM/STM fields. increment/pre_indexed select IA/IB/DA/DB.
    typedef struct packed {
        reg_num_t              rn;
        logic                  increment;
        logic                  pre_indexed;
        logic                  writeback;
        logic                  load;
        logic                  user_regs;
        logic [NUM_REGS-1:0]   reg_list;
    } ldst_decode_t;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ldst_mult_state_t;

    // Number of set bits in a 16-bit register list (0..16).
    function automatic logic [4:0] popcount16(input logic [NUM_REGS-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {4'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_ldst_multiple_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : core_ldst_multiple_seq_if
// Description : Request, beat and writeback signals of the LDM/STM sequencer.
//               master = issuing core / memory side, slave = the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_ldst_multiple_seq_if;
    import core_ldst_multiple_seq_pkg::*;

    logic         start;
    logic         ready;
    ldst_decode_t decode_in;
    word_t        base;
    logic         beat_valid;
    logic         beat_ready;
    word_t        beat_addr;
    reg_num_t     beat_reg;
    logic         beat_load;
    logic         beat_user;
    logic         beat_last;
    logic         done;
    logic         wb_valid;
    reg_num_t     wb_reg;
    word_t        wb_value;

    modport master (
        output start, decode_in, base, beat_ready,
        input  ready, beat_valid, beat_addr, beat_reg, beat_load, beat_user,
               beat_last, done, wb_valid, wb_reg, wb_value
    );

    modport slave (
        input  start, decode_in, base, beat_ready,
        output ready, beat_valid, beat_addr, beat_reg, beat_load, beat_user,
               beat_last, done, wb_valid, wb_reg, wb_value
    );
endinterface
`default_nettype wire

// File: rtl/core_ldst_mult_prio.sv
`default_nettype none
// ============================================================================
// Module      : core_ldst_mult_prio
// Description : 16-bit lowest-set-bit encoder. idx_o is the index of the
//               lowest set bit (0 when empty); single_o flags that exactly
//               one bit is set, which marks the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module core_ldst_mult_prio (
    input  logic [15:0] mask_i,
    output logic [3:0]  idx_o,
    output logic        single_o
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx_o = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

    // A non-empty mask with no bit left after clearing its lowest one.
    assign single_o = (mask_i != 16'h0) && ((mask_i & (mask_i - 16'h1)) == 16'h0);

endmodule
`default_nettype wire

// File: rtl/core_ldst_multiple_seq.sv
`default_nettype none
// ============================================================================
// Module      : core_ldst_multiple_seq
// Description : LDM/STM sequencer. Accepts one decoded multiple-transfer
//               instruction, emits one beat per listed register in ascending
//               register order with ascending addresses, then pulses done
//               together with the base-register writeback request.
// Revision    : 1.0 - initial release
// ============================================================================
module core_ldst_multiple_seq
    import core_ldst_multiple_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    core_ldst_multiple_seq_if.slave  bus
);

    ldst_mult_state_t state_q, state_d;
    logic [15:0]      mask_q, mask_d;
    word_t            addr_q, addr_d;
    logic             load_q, load_d;
    logic             user_q, user_d;
    logic             wbv_q, wbv_d;
    reg_num_t         wbreg_q, wbreg_d;
    word_t            wbval_q, wbval_d;

    logic [3:0]       w_prio_idx;
    logic             w_prio_single;
    logic [4:0]       w_count;
    word_t            w_span;
    word_t            w_start_addr;
    logic             w_in_run;
    logic             w_in_done;

    core_ldst_mult_prio u_prio (
        .mask_i   (mask_q),
        .idx_o    (w_prio_idx),
        .single_o (w_prio_single)
    );

    // Transfer span 4n of the incoming instruction.
    assign w_count = popcount16(bus.decode_in.reg_list);
    assign w_span  = {25'b0, w_count, 2'b00};

    // Lowest address touched: IA base, IB base+4, DA base-4n+4, DB base-4n.
    always_comb begin
        unique case ({bus.decode_in.increment, bus.decode_in.pre_indexed})
            2'b10:   w_start_addr = bus.base;
            2'b11:   w_start_addr = bus.base + 32'd4;
            2'b00:   w_start_addr = bus.base - w_span + 32'd4;
            default: w_start_addr = bus.base - w_span;
        endcase
    end

    // Next-state logic: latch on start in IDLE, retire one beat per handshake.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        load_d  = load_q;
        user_d  = user_q;
        wbv_d   = wbv_q;
        wbreg_d = wbreg_q;
        wbval_d = wbval_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d  = bus.decode_in.reg_list;
                    addr_d  = {w_start_addr[31:2], 2'b00};
                    load_d  = bus.decode_in.load;
                    user_d  = bus.decode_in.user_regs;
                    wbreg_d = bus.decode_in.rn;
                    // A loaded base register wins over the writeback.
                    wbv_d   = bus.decode_in.writeback &&
                              !(bus.decode_in.load && bus.decode_in.reg_list[bus.decode_in.rn]);
                    wbval_d = bus.decode_in.increment ? (bus.base + w_span)
                                                      : (bus.base - w_span);
                    state_d = (w_count != 5'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (bus.beat_ready) begin
                    mask_d = mask_q & ~(16'h1 << w_prio_idx);
                    addr_d = addr_q + 32'd4;
                    if (w_prio_single) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            user_q  <= 1'b0;
            wbv_q   <= 1'b0;
            wbreg_q <= '0;
            wbval_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            user_q  <= user_d;
            wbv_q   <= wbv_d;
            wbreg_q <= wbreg_d;
            wbval_q <= wbval_d;
        end
    end

    // Outputs are zeroed outside the state that qualifies them.
    assign w_in_run  = (state_q == ST_RUN);
    assign w_in_done = (state_q == ST_DONE);

    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.beat_valid = w_in_run;
    assign bus.beat_addr  = w_in_run ? addr_q : '0;
    assign bus.beat_reg   = w_in_run ? w_prio_idx : '0;
    assign bus.beat_load  = w_in_run & load_q;
    assign bus.beat_user  = w_in_run & user_q;
    assign bus.beat_last  = w_in_run & w_prio_single;
    assign bus.done       = w_in_done;
    assign bus.wb_valid   = w_in_done & wbv_q;
    assign bus.wb_reg     = w_in_done ? wbreg_q : '0;
    assign bus.wb_value   = w_in_done ? wbval_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_ldst_multiple_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_ldst_multiple_seq
// Description : Self-checking bench for the LDM/STM sequencer: a table of
//               instructions with expected start address and writeback, a
//               beat scoreboard filled at issue and drained on handshakes,
//               plus a hand-written mid-instruction reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ldst_multiple_seq;
    import core_ldst_multiple_seq_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rg;
        logic        last;
        logic        load;
        logic        user;
    } beat_t;

    typedef struct {
        ldst_decode_t dec;
        logic [31:0]  base;
        logic [31:0]  exp_first;
        logic         exp_wbv;
        logic [31:0]  exp_wbval;
        int           stall_beat;
        int           stall_cycles;
    } vec_t;

    logic  clk;
    logic  rst_n;
    int    n_pass;
    int    n_total;
    beat_t sb_q[$];
    vec_t  vecs[8];

    core_ldst_multiple_seq_if bus ();

    core_ldst_multiple_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic ldst_decode_t mk_dec(input logic [3:0] rn, input logic inc,
                                            input logic pre, input logic wb,
                                            input logic ld, input logic usr,
                                            input logic [15:0] list);
        ldst_decode_t d;
        d.rn          = rn;
        d.increment   = inc;
        d.pre_indexed = pre;
        d.writeback   = wb;
        d.load        = ld;
        d.user_regs   = usr;
        d.reg_list    = list;
        return d;
    endfunction

    // Issue one instruction and follow it to done, scoring every beat.
    task automatic run_instr(input string tag, input vec_t v);
        int          n;
        int          k;
        int          cyc;
        int          accepted;
        int          stalled;
        int          pres;
        int          stall_total;
        bit          fin;
        logic [31:0] a;
        logic [31:0] r;
        beat_t       b;
        beat_t       got;

        n = 0;
        for (int i = 0; i < 16; i++) if (v.dec.reg_list[i]) n++;
        a = v.exp_first;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (v.dec.reg_list[i]) begin
                k++;
                b.addr = a;
                b.rg   = 4'(i);
                b.last = (k == n);
                b.load = v.dec.load;
                b.user = v.dec.user_regs;
                sb_q.push_back(b);
                a = a + 32'd4;
            end
        end
        stall_total = (v.stall_beat < n) ? v.stall_cycles : 0;

        @(negedge clk);
        chk({tag, " ready_before_start"}, 64'(bus.ready), 64'd1);
        bus.start     = 1'b1;
        bus.decode_in = v.dec;
        bus.base      = v.base;
        @(negedge clk);
        bus.start = 1'b0;
        cyc       = 1;
        fin       = 0;
        accepted  = 0;
        stalled   = 0;
        pres      = 0;
        while (!fin && cyc < 80) begin
            // A start while busy must be ignored.
            if (cyc == 2 && n >= 2) begin
                r             = $urandom;
                bus.start     = 1'b1;
                bus.decode_in = r[25:0];
                bus.base      = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            bus.beat_ready = !(accepted == v.stall_beat && stalled < v.stall_cycles);
            if (bus.done) begin
                fin = 1;
                chk({tag, " done_cycle"}, 64'(cyc), 64'(n + 1 + stall_total));
                chk({tag, " beat_valid_in_done"}, 64'(bus.beat_valid), 64'd0);
                chk({tag, " wb_valid"}, 64'(bus.wb_valid), 64'(v.exp_wbv));
                chk({tag, " wb_reg"}, 64'(bus.wb_reg), 64'(v.dec.rn));
                chk({tag, " wb_value"}, 64'(bus.wb_value), 64'(v.exp_wbval));
                chk({tag, " beats_missing"}, 64'(sb_q.size()), 64'd0);
            end else if (bus.beat_valid) begin
                if (sb_q.size() == 0) begin
                    chk({tag, " extra_beat"}, 64'd1, 64'd0);
                end else begin
                    got.addr = bus.beat_addr;
                    got.rg   = bus.beat_reg;
                    got.last = bus.beat_last;
                    got.load = bus.beat_load;
                    got.user = bus.beat_user;
                    chk($sformatf("%s beat%0d", tag, accepted), 64'(got), 64'(sb_q[0]));
                    if (accepted == v.stall_beat) pres++;
                    if (bus.beat_ready) begin
                        void'(sb_q.pop_front());
                        accepted++;
                    end else begin
                        stalled++;
                    end
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start      = 1'b0;
        bus.beat_ready = 1'b1;
        if (!fin) chk({tag, " timeout_no_done"}, 64'd1, 64'd0);
        if (stall_total > 0) chk({tag, " stall_hold_cycles"}, 64'(pres), 64'(stall_total + 1));
        @(negedge clk);
        chk({tag, " idle_after_done"}, {61'd0, bus.ready, bus.done, bus.wb_valid}, 64'b100);
        sb_q.delete();
    endtask

    initial begin
        int        seen;
        vec_t      rv;
        beat_t     b0;
        beat_t     got;

        n_pass  = 0;
        n_total = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.decode_in  = '0;
        bus.base       = '0;
        bus.beat_ready = 1'b1;

        // rn inc pre wb ld usr list ; base ; first addr ; wbv ; wb value ; stall beat/cycles
        vecs[0] = '{mk_dec(4'd0,  1,0,1,1,0,16'h000E), 32'h1000, 32'h1000,     1'b1, 32'h100C,     99, 0};
        vecs[1] = '{mk_dec(4'd13, 0,1,1,0,0,16'h4010), 32'h2000, 32'h1FF8,     1'b1, 32'h1FF8,     99, 0};
        vecs[2] = '{mk_dec(4'd1,  1,1,0,1,0,16'h8000), 32'h3000, 32'h3004,     1'b0, 32'h3004,     99, 0};
        vecs[3] = '{mk_dec(4'd0,  1,0,1,1,0,16'h0003), 32'h5000, 32'h5000,     1'b0, 32'h5008,     1,  3};
        vecs[4] = '{mk_dec(4'd2,  1,0,1,1,0,16'h0000), 32'h4000, 32'h0,        1'b1, 32'h4000,     99, 0};
        vecs[5] = '{mk_dec(4'd2,  0,0,1,0,1,16'h8081), 32'h0010, 32'h0008,     1'b1, 32'h0004,     0,  1};
        vecs[6] = '{mk_dec(4'd3,  0,1,1,1,0,16'hFFFF), 32'h0004, 32'hFFFFFFC4, 1'b0, 32'hFFFFFFC4, 15, 2};
        vecs[7] = '{mk_dec(4'd5,  1,1,1,0,1,16'h0020), 32'h0100, 32'h0104,     1'b1, 32'h0104,     99, 0};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(bus.ready), 64'd1);
        chk("reset outputs", {bus.beat_valid, bus.beat_addr, bus.beat_reg, bus.done, bus.wb_valid},
            64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_instr($sformatf("v%0d", i), vecs[i]);
        end

        // Reset during beat 2 of LDMIA r0!,{r4-r7}.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.decode_in = mk_dec(4'd0, 1, 0, 1, 1, 0, 16'h00F0);
        bus.base      = 32'h8000;
        @(negedge clk);
        bus.start = 1'b0;
        b0 = '{addr: 32'h8000, rg: 4'd4, last: 1'b0, load: 1'b1, user: 1'b0};
        got = '{addr: bus.beat_addr, rg: bus.beat_reg, last: bus.beat_last,
                load: bus.beat_load, user: bus.beat_user};
        chk("rst_seq beat1", 64'(got), 64'(b0));
        @(negedge clk);
        chk("rst_seq beat2 addr", 64'(bus.beat_addr), 64'h8004);
        rst_n = 1'b0;
        #1;
        chk("rst_seq ready", 64'(bus.ready), 64'd1);
        chk("rst_seq outputs zero",
            {bus.beat_valid, bus.beat_last, bus.beat_reg, bus.beat_load, bus.done, bus.wb_valid,
             bus.beat_addr[15:0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.beat_valid || bus.done) seen++;
        end
        chk("rst_seq no activity after abort", 64'(seen), 64'd0);
        rv = vecs[0];
        run_instr("after_reset", rv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_ldst_multiple_seq.md
CORE_LDST_MULTIPLE_SEQ -- requirements
Module: core_ldst_multiple_seq

Interface
REQ-001 Parameters: none; all widths fixed by the shared ISA/uarch types.
REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request to accept a new LDM/STM; honoured only when ready=1.
REQ-006 ready  out  1  sequencer idle; able to accept start.
REQ-007 decode_in  in  ldst_decode  decoded LDM/STM fields: rn, increment, pre_indexed, writeback, load, user_regs, reg_list.
REQ-008 base  in  word  current value of Rn, sampled with start.
REQ-009 beat_valid  out  1  one register transfer is presented.
REQ-010 beat_ready  in  1  memory side accepts the current beat.
REQ-011 beat_addr  out  word  word-aligned transfer address.
REQ-012 beat_reg  out  4  register number transferred.
REQ-013 beat_load / beat_user  out  1 each  latched load and user_regs flags.
REQ-014 beat_last  out  1  current beat is the final one.
REQ-015 done  out  1  one-cycle pulse at instruction completion.
REQ-016 wb_valid / wb_reg / wb_value  out  1 / 4 / word  base writeback request, qualified by done.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; ready=1 only in IDLE.
REQ-018 In IDLE, start&ready SHALL latch decode_in, base, pending mask = reg_list and n = popcount(reg_list), then enter RUN (n>0) or DONE (n=0); start with ready=0 SHALL be ignored.
REQ-019 Start address SHALL be: IA base; IB base+4; DA base-4n+4; DB base-4n; all arithmetic modulo 2^32, bits [1:0] forced to 00.
REQ-020 Writeback value SHALL be base+4n (increment=1) or base-4n (increment=0).
REQ-021 In RUN, beat_valid=1, beat_reg = lowest set bit of pending mask, beat_addr = current address, beat_last=1 when exactly one bit remains.
REQ-022 On beat_valid&beat_ready the SHALL clear that bit and add 4 to the address; on the last beat the next state SHALL be DONE.
REQ-023 While beat_valid&!beat_ready all beat_* outputs SHALL hold stable.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 wb_valid SHALL be 1 in DONE iff writeback=1 and not (load=1 and reg_list[rn]=1); wb_reg=rn.
REQ-026 Latency: start accepted cycle 0, first beat cycle 1, with beat_ready held 1 done is in cycle n+1; empty list gives done in cycle 1, no beats, wb_value=base.
REQ-027 Outside RUN beat_valid=0; outside DONE done=0 and wb_valid=0.

Reset
REQ-028 On rst_n low, at any time including mid-instruction, state SHALL go IDLE, pending mask cleared, all outputs 0 except ready=1; the aborted instruction SHALL produce no further beats or done.

Structure
REQ-029 State enum ldst_mult_state SHALL be added to the shared uarch package; ldst_decode, word and register-number types SHALL come from the existing shared packages.
REQ-030 A sub-module core_ldst_mult_prio (16-bit lowest-set-bit encoder: 4-bit index plus single-bit flag) SHALL be instantiated for beat_reg/beat_last.

Verification
REQ-031 LDMIA r0!,{r1,r2,r3}, base 0x1000, beat_ready=1 -> r1@0x1000, r2@0x1004, r3@0x1008 (last); done cycle 4, wb r0=0x100C.
REQ-032 STMDB r13!,{r4,r14}, base 0x2000 -> r4@0x1FF8, r14@0x1FFC; wb_value 0x1FF8, beat_load=0.
REQ-033 LDMIB r1,{r15}, base 0x3000, writeback=0 -> one beat r15@0x3004 with last=1; wb_valid=0.
REQ-034 LDMIA r0!,{r0,r1} with beat_ready low 3 cycles on beat 2 -> r1@base+4 held stable 4 cycles; wb_valid=0.
REQ-035 Empty reg_list, base 0x4000, writeback=1 -> no beat_valid, done in cycle 1, wb_value 0x4000.
REQ-036 rst_n pulsed low during beat 2 of a 4-register LDM -> outputs 0 immediately, ready=1; no done; next start sequences normally.
